// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Brief    : Mono left-justified serializer for the WM8731 DAC; generates
//            BCLK/DACLRCK/DACDAT and a per-frame sample-latch pulse.
//            Optional macro AUDIO_UNSIGNED_IN_EN: offset-binary sample input.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
  parameter int BCLK_DIV = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        INIT_FINISH,
  input  logic [15:0] sample_in,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        data_over
);

  localparam int                 c_DIV_W   = $clog2(BCLK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [0:0]         c_IDLE    = 1'b0;
  localparam logic [0:0]         c_RUN     = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic [c_DIV_W-1:0] w_div_nxt;
  logic [4:0]         r_bit_cnt;
  logic [4:0]         w_bit_nxt;
  logic [4:0]         w_bit_inc;
  logic [31:0]        r_shreg;
  logic [31:0]        w_shreg_nxt;
  logic               r_bclk;
  logic               w_bclk_nxt;
  logic               r_lrck;
  logic               w_lrck_nxt;
  logic               r_data_over;
  logic               w_data_over_nxt;
  logic [15:0]        w_sample;
  logic               w_wrap;
  logic               w_fall;
  logic               w_latch;

`ifdef AUDIO_UNSIGNED_IN_EN
  assign w_sample = {~sample_in[15], sample_in[14:0]};
`else
  assign w_sample = sample_in;
`endif

  assign w_wrap    = (r_div_cnt == c_DIV_MAX);
  assign w_fall    = w_wrap & r_bclk;
  assign w_bit_inc = r_bit_cnt + 5'd1;
  // A latch needs INIT_FINISH high: dropping it on a frame boundary means IDLE, no pulse.
  assign w_latch   = INIT_FINISH & ((r_state == c_IDLE) | (w_fall & (r_bit_cnt == 5'd31)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (INIT_FINISH)  w_state_nxt = c_RUN;
      c_RUN:   if (!INIT_FINISH) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_div_nxt       = '0;
    w_bit_nxt       = '0;
    w_shreg_nxt     = '0;
    w_bclk_nxt      = 1'b0;
    w_lrck_nxt      = 1'b0;
    w_data_over_nxt = 1'b0;
    if (w_state_nxt == c_RUN) begin
      if (w_latch) begin
        w_shreg_nxt     = {w_sample, w_sample};
        w_lrck_nxt      = 1'b1;
        w_data_over_nxt = 1'b1;
      end else begin
        w_div_nxt   = w_wrap ? '0 : r_div_cnt + c_DIV_W'(1);
        w_bclk_nxt  = r_bclk ^ w_wrap;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_lrck_nxt  = r_lrck;
        if (w_fall) begin
          w_bit_nxt   = w_bit_inc;
          w_shreg_nxt = {r_shreg[30:0], 1'b0};
          w_lrck_nxt  = ~w_bit_inc[4];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_data_over <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bclk      <= w_bclk_nxt;
      r_lrck      <= w_lrck_nxt;
      r_data_over <= w_data_over_nxt;
    end
  end

  assign AUD_BCLK    = r_bclk;
  assign AUD_DACLRCK = r_lrck;
  assign AUD_DACDAT  = r_shreg[31];
  assign data_over   = r_data_over;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Brief    : Self-checking bench for audio_i2s_tx (BCLK_DIV 4 and 16 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        INIT_FINISH;
  logic [15:0] sample_in;
  logic        bclk4, lrck4, dat4, dov4;
  logic        bclk16, lrck16, dat16, dov16;
  logic        cmp_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 Clk = ~Clk;

  audio_i2s_tx #(.BCLK_DIV(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .sample_in(sample_in),
    .AUD_BCLK(bclk4), .AUD_DACLRCK(lrck4), .AUD_DACDAT(dat4), .data_over(dov4)
  );

  audio_i2s_tx #(.BCLK_DIV(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .sample_in(sample_in),
    .AUD_BCLK(bclk16), .AUD_DACLRCK(lrck16), .AUD_DACDAT(dat16), .data_over(dov16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] to_s(input logic [15:0] x);
`ifdef AUDIO_UNSIGNED_IN_EN
    return {~x[15], x[14:0]};
`else
    return x;
`endif
  endfunction

  function automatic int d_of(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  // Frame-level model: t = cycles since the latch, word = latched {s,s}.
  logic        m_run [2];
  int          m_t   [2];
  logic [31:0] m_w   [2];

  // Expected {BCLK, LRCK, DACDAT, data_over}
  function automatic logic [3:0] model_out(input logic run, input int t, input int d,
                                           input logic [31:0] w);
    int b;
    if (!run) return 4'b0000;
    b = t / (2 * d);
    return {1'(((t / d) % 2) == 1), 1'(b < 16), w[31 - b], 1'(t == 0)};
  endfunction

  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (Reset || !INIT_FINISH) begin
        m_run[k] <= 1'b0;
        m_t[k]   <= 0;
      end else if (!m_run[k] || m_t[k] == 64 * d_of(k) - 1) begin
        m_run[k] <= 1'b1;
        m_t[k]   <= 0;
        m_w[k]   <= {to_s(sample_in), to_s(sample_in)};
      end else begin
        m_t[k] <= m_t[k] + 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cyc_dut4", {28'd0, bclk4, lrck4, dat4, dov4},
          {28'd0, model_out(m_run[0], m_t[0], 4, m_w[0])});
      chk("cyc_dut16", {28'd0, bclk16, lrck16, dat16, dov16},
          {28'd0, model_out(m_run[1], m_t[1], 16, m_w[1])});
    end
  end

  // Called on a negedge showing data_over; returns on the next one, or after a bound.
  task automatic capture4(input int chg_at, input logic [15:0] chg_val,
                          output logic [31:0] w, output logic [31:0] lr, output int len);
    logic pb;
    int   nb;
    w = '0; lr = '0; len = 0; nb = 0; pb = bclk4;
    while (len < 2000) begin
      @(negedge Clk);
      len++;
      if (!pb && bclk4 && nb < 32) begin
        w  = {w[30:0], dat4};
        lr = {lr[30:0], lrck4};
        nb++;
        if (nb == chg_at) sample_in = chg_val;
      end
      pb = bclk4;
      if (dov4) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, lr;
    int          len, gap;
    Reset = 1'b1; INIT_FINISH = 1'b1; sample_in = 16'h8001;
    @(negedge Clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("reset_out", {28'd0, bclk4, lrck4, dat4, dov4}, 32'd0);
    end
    Reset = 1'b0;
    @(negedge Clk);
    chk("first_pulse", {31'd0, dov4}, 32'd1);
    chk("first_lrck", {31'd0, lrck4}, 32'd1);

    sample_in = 16'hAAAA;
    capture4(-1, 16'h0, w, lr, len);
    chk("frame_8001", w, {to_s(16'h8001), to_s(16'h8001)});
    chk("lrck_slots", lr, 32'hFFFF0000);
    chk("frame_len", len, 256);
`ifndef AUDIO_UNSIGNED_IN_EN
    chk("frame_8001_lit", w, 32'h80018001);
`endif

    capture4(10, 16'h5555, w, lr, len);
    chk("frame_aaaa", w, {to_s(16'hAAAA), to_s(16'hAAAA)});
    capture4(-1, 16'h0, w, lr, len);
    chk("frame_5555", w, {to_s(16'h5555), to_s(16'h5555)});

    repeat (160) @(negedge Clk);
    INIT_FINISH = 1'b0;
    @(negedge Clk);
    chk("shutdown_out", {28'd0, bclk4, lrck4, dat4, dov4}, 32'd0);
    repeat (3) @(negedge Clk);
    sample_in = 16'h0F0F;
    INIT_FINISH = 1'b1;
    @(negedge Clk);
    chk("restart_pulse", {31'd0, dov4}, 32'd1);
    chk("restart_lrck", {31'd0, lrck4}, 32'd1);

    for (int f = 0; f < 5; f++) begin
      gap = 1;
      @(negedge Clk);
      chk("pulse_width", {31'd0, dov16}, 32'd0);
      while (!dov16 && gap < 3000) begin
        @(negedge Clk);
        gap++;
      end
      chk("pulse_gap", gap, 1024);
    end

    chk("dut4_aligned", {31'd0, dov4}, 32'd1);
    sample_in = 16'h0000;
    capture4(-1, 16'h0, w, lr, len);
    chk("frame_0f0f", w, {to_s(16'h0F0F), to_s(16'h0F0F)});
    sample_in = 16'hFFFF;
    capture4(-1, 16'h0, w, lr, len);
`ifdef AUDIO_UNSIGNED_IN_EN
    chk("conv_0000", w, 32'h80008000);
`else
    chk("conv_0000", w, 32'h00000000);
`endif
    capture4(-1, 16'h0, w, lr, len);
`ifdef AUDIO_UNSIGNED_IN_EN
    chk("conv_ffff", w, 32'h7FFF7FFF);
`else
    chk("conv_ffff", w, 32'hFFFFFFFF);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
